// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Sequencing controller and shift-add datapath for the unsigned
//   A_WIDTH x B_WIDTH sequential multiplier. The controller drives an external
//   iteration counter (WIDTH=CNT_WIDTH, MAX_COUNT=A_WIDTH-1) through a
//   registered enable and a registered clear. It cross-checks the counter's
//   value against its own iteration index on every step.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  operands accepted (high only while idle)
//   a_in       in   multiplier, unsigned, A_WIDTH bits
//   b_in       in   multiplicand, unsigned, B_WIDTH bits
//   cnt_en     out  registered enable to the iteration counter
//   cnt_clr    out  registered clear to the iteration counter (active high)
//   cnt_value  in   current count from the iteration counter
//   out_valid  out  product valid
//   out_ready  in   downstream accepts product
//   product    out  unsigned product, A_WIDTH+B_WIDTH bits, stable while valid
//   busy       out  high while loading or iterating
//   cnt_err    out  sticky: counter value disagreed with the iteration index
// ---------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 24,
  parameter int CNT_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a_in,
  input  logic [B_WIDTH-1:0]         b_in,
  output logic                       cnt_en,
  output logic                       cnt_clr,
  input  logic [CNT_WIDTH-1:0]       cnt_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       busy,
  output logic                       cnt_err
);

  localparam int P_W = A_WIDTH + B_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(A_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [P_W-1:0]       acc_q, acc_d;
  logic [B_WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic                 cnt_en_q, cnt_en_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic                 cnt_err_q, cnt_err_d;

  // One shift-add step. The accumulator holds the partial product in its
  // upper B_WIDTH bits and the not-yet-consumed multiplier bits in its lower
  // A_WIDTH bits. The carry of the add becomes the new MSB after the right
  // shift, and the consumed multiplier LSB falls off the bottom, so the
  // shifted result fits exactly in A_WIDTH+B_WIDTH bits.
  function automatic logic [P_W-1:0] shift_add_step(
    input logic [P_W-1:0]     acc,
    input logic [B_WIDTH-1:0] mcand
  );
    logic [B_WIDTH:0] sum;
    sum = {1'b0, acc[P_W-1:A_WIDTH]};
    if (acc[0]) begin
      sum = sum + {1'b0, mcand};
    end
    return {sum, acc[A_WIDTH-1:1]};
  endfunction

  // Next-state / datapath logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    idx_d     = idx_q;
    cnt_en_d  = cnt_en_q;
    cnt_clr_d = cnt_clr_q;
    cnt_err_d = cnt_err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d   = b_in;
          acc_d     = {{B_WIDTH{1'b0}}, a_in};
          cnt_err_d = 1'b0;
          // Release the counter clear so it is low from LOAD onward.
          cnt_clr_d = 1'b0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        // Enable goes high together with entry to RUN, so the counter reads
        // 0 on the first iteration and advances in lockstep with idx.
        cnt_en_d = 1'b1;
        idx_d    = '0;
        state_d  = S_RUN;
      end

      S_RUN: begin
        acc_d = shift_add_step(acc_q, mcand_q);
        if (cnt_value != idx_q) begin
          cnt_err_d = 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // The counter wraps to 0 on this same edge at MAX_COUNT.
          cnt_en_d = 1'b0;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          cnt_clr_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and accumulator registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b1;
      cnt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  // Multiplicand register: only ever read after an accept reloads it, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
  end

  // Outputs
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign product   = acc_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_ctrl
//   Directed bench for mult_seq_ctrl with a behavioural iteration counter
//   (WIDTH=5, MAX_COUNT=15) that can be made to skip a value. Expected
//   products are queued at accept time and compared when the product is
//   handed off.
// ---------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  localparam int A_W = 16;
  localparam int B_W = 24;
  localparam int C_W = 5;
  localparam int P_W = A_W + B_W;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a_in;
  logic [B_W-1:0] b_in;
  logic           cnt_en;
  logic           cnt_clr;
  logic [C_W-1:0] cnt_value;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] product;
  logic           busy;
  logic           cnt_err;

  logic           skip_inj;

  int n_vec;
  int n_err;
  logic [63:0] exp_q[$];

  mult_seq_ctrl #(
    .A_WIDTH  (A_W),
    .B_WIDTH  (B_W),
    .CNT_WIDTH(C_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .cnt_value(cnt_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy),
    .cnt_err  (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Iteration counter model; skip_inj makes it jump 5 -> 7.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_value <= '0;
    end else if (cnt_clr) begin
      cnt_value <= '0;
    end else if (cnt_en) begin
      if (skip_inj && cnt_value == 5'd5) cnt_value <= 5'd7;
      else if (cnt_value == 5'd15)       cnt_value <= '0;
      else                               cnt_value <= cnt_value + 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every handed-off product with the queue head.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_product: observed=%0h expected=none", product);
      end else begin
        chk("product", 64'(product), exp_q.pop_front());
      end
    end
  end

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Present operands and wait (bounded) for the accept edge. in_valid is left
  // high; the caller decides when to drop it.
  task automatic accept(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input bit push, output int waited);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    if (push) exp_q.push_back(64'(a) * 64'(b));
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int cyc;
    int w;
    int en_cnt;
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    skip_inj  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_cnt_en",    64'(cnt_en),    64'd0);
    chk("rst_cnt_clr",   64'(cnt_clr),   64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product",   64'(product),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_cnt_err",   64'(cnt_err),   64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 3 x 5: latency and single-cycle out_valid pulse
    accept(16'h0003, 24'h000005, 1'b1, w);
    in_valid = 1'b0;
    chk("load_busy",     64'(busy),     64'd1);
    chk("load_cnt_clr",  64'(cnt_clr),  64'd0);
    chk("load_in_ready", 64'(in_ready), 64'd0);
    wait_out(cyc);
    chk("latency", 64'(cyc), 64'd17);
    chk("prod_3x5", 64'(product), 64'h0000000000F);
    @(posedge clk); #1;
    chk("valid_pulse_end", 64'(out_valid), 64'd0);
    chk("idle_cnt_clr",    64'(cnt_clr),   64'd1);

    // Max operands: cnt_en high for exactly A_W cycles
    accept(16'hFFFF, 24'hFFFFFF, 1'b1, w);
    in_valid = 1'b0;
    en_cnt = 0;
    cyc    = 0;
    while (!out_valid && cyc < 200) begin
      en_cnt += int'(cnt_en);
      @(posedge clk); #1;
      cyc++;
    end
    chk("max_out_valid", 64'(out_valid), 64'd1);
    chk("max_cnt_en_cycles", 64'(en_cnt), 64'd16);
    chk("max_cnt_en_done",   64'(cnt_en), 64'd0);
    chk("max_product", 64'(product), 64'hFFFEFF0001);
    chk("max_cnt_err", 64'(cnt_err), 64'd0);
    @(posedge clk); #1;

    // Output backpressure for 10 cycles
    out_ready = 1'b0;
    accept(16'h8000, 24'h800000, 1'b1, w);
    in_valid = 1'b0;
    wait_out(cyc);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid",    64'(out_valid), 64'd1);
      chk("hold_product",  64'(product),   64'h4000000000);
      chk("hold_in_ready", 64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    chk("hold_release_ready", 64'(in_ready),  64'd1);

    // Back-to-back with in_valid held high
    accept(16'h1234, 24'h000000, 1'b1, w);
    accept(16'h0001, 24'hABCDEF, 1'b1, w);
    chk("b2b_second_wait", 64'(w), 64'd18);
    in_valid = 1'b0;
    wait_out(cyc);
    chk("b2b_product", 64'(product), 64'h0000ABCDEF);
    @(posedge clk); #1;

    // Reset pulsed during RUN iteration 7
    accept(16'h00FF, 24'h000123, 1'b0, w);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt_clr",   64'(cnt_clr),   64'd1);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst_cnt_en",    64'(cnt_en),    64'd0);
    chk("mid_rst_product",   64'(product),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    accept(16'h0002, 24'h000002, 1'b1, w);
    in_valid = 1'b0;
    wait_out(cyc);
    chk("post_rst_product", 64'(product), 64'h0000000004);
    chk("post_rst_latency", 64'(cyc), 64'd17);
    @(posedge clk); #1;

    // Counter skips a value: sticky cnt_err, cleared by the next accept
    skip_inj = 1'b1;
    accept(16'h0101, 24'h000010, 1'b1, w);
    in_valid = 1'b0;
    wait_out(cyc);
    chk("skip_cnt_err", 64'(cnt_err), 64'd1);
    @(posedge clk); #1;
    chk("skip_cnt_err_idle", 64'(cnt_err), 64'd1);
    skip_inj = 1'b0;
    accept(16'h0001, 24'h000001, 1'b1, w);
    in_valid = 1'b0;
    chk("clean_cnt_err_load", 64'(cnt_err), 64'd0);
    wait_out(cyc);
    chk("clean_cnt_err_done", 64'(cnt_err), 64'd0);
    chk("clean_product", 64'(product), 64'h0000000001);
    @(posedge clk); #1;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
